slow_hold_timer: RTL and testbench

// - Consumer of the slow-device settings register: watches each bus cycle, detects accesses to

---
 rtl/slow_hold_timer_pkg.sv | 15 +
 rtl/slow_hold_timer_if.sv | 66 ++++++
 rtl/slow_hold_timer_prescaler.sv | 37 +++
 rtl/slow_hold_timer.sv | 109 ++++++++++
 tb/tb_slow_hold_timer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slow_hold_timer_pkg.sv
// Shared types and constants for the slow-device hold timer.
// Optional hit counter is enabled with SLOW_HITCNT_EN.
package slow_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int unsigned TICK_DIV_DEF = 16;
  localparam int unsigned TMO_W        = 4;
  localparam int unsigned HIT_W        = 8;

endpackage

// File: rtl/slow_hold_timer_if.sv
// Bus-cycle decode, slow settings and slow-mode requests.
// SLOW_HITCNT_EN adds ClrHits/SlowHits.
interface slow_hold_timer_if;
  import slow_pkg::*;

  logic             BACT;
  logic             IACKCyc;
  logic             VIACS;
  logic             IWMCS;
  logic             SCCCS;
  logic             SCSICS;
  logic             SndCyc;
  logic             SlowIACK;
  logic             SlowVIA;
  logic             SlowIWM;
  logic             SlowSCC;
  logic             SlowSCSI;
  logic             SlowSnd;
  logic             SlowClockGate;
  logic [TMO_W-1:0] SlowTimeout;
  logic             Slow;
  logic             ClockGate;
`ifdef SLOW_HITCNT_EN
  logic             ClrHits;
  logic [HIT_W-1:0] SlowHits;

  modport master (
    output BACT, IACKCyc, VIACS, IWMCS,
    output SCCCS, SCSICS, SndCyc,
    output SlowIACK, SlowVIA, SlowIWM,
    output SlowSCC, SlowSCSI, SlowSnd,
    output SlowClockGate, SlowTimeout,
    output ClrHits,
    input  Slow, ClockGate, SlowHits
  );

  modport slave (
    input  BACT, IACKCyc, VIACS, IWMCS,
    input  SCCCS, SCSICS, SndCyc,
    input  SlowIACK, SlowVIA, SlowIWM,
    input  SlowSCC, SlowSCSI, SlowSnd,
    input  SlowClockGate, SlowTimeout,
    input  ClrHits,
    output Slow, ClockGate, SlowHits
  );
`else
  modport master (
    output BACT, IACKCyc, VIACS, IWMCS,
    output SCCCS, SCSICS, SndCyc,
    output SlowIACK, SlowVIA, SlowIWM,
    output SlowSCC, SlowSCSI, SlowSnd,
    output SlowClockGate, SlowTimeout,
    input  Slow, ClockGate
  );

  modport slave (
    input  BACT, IACKCyc, VIACS, IWMCS,
    input  SCCCS, SCSICS, SndCyc,
    input  SlowIACK, SlowVIA, SlowIWM,
    input  SlowSCC, SlowSCSI, SlowSnd,
    input  SlowClockGate, SlowTimeout,
    output Slow, ClockGate
  );
`endif

endinterface

// File: rtl/slow_hold_timer_prescaler.sv
// Timeout tick divider: counts 0..DIV-1 while enabled,
// one-cycle tick on the last count, clear has priority.
module slow_prescaler #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/slow_hold_timer.sv
// Requests slow bus mode on slow-device accesses and holds it for
// SlowTimeout*TICK_DIV clocks after the access; SLOW_HITCNT_EN adds a hit counter.
module slow_hold_timer
  import slow_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input logic              CLK,
  input logic              nPOR,
  slow_hold_timer_if.slave bus
);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             slow_q, gate_q;
  logic             hit, tick, in_hold, slow_d;

  assign hit = bus.BACT & (
      (bus.IACKCyc & bus.SlowIACK)
    | (bus.VIACS   & bus.SlowVIA)
    | (bus.IWMCS   & bus.SlowIWM)
    | (bus.SCCCS   & bus.SlowSCC)
    | (bus.SCSICS  & bus.SlowSCSI)
    | (bus.SndCyc  & bus.SlowSnd));

  assign in_hold = (state_q == HOLD);

  // Prescaler only runs in HOLD, so every hold starts on a fresh tick.
  slow_prescaler #(
    .DIV(TICK_DIV)
  ) u_pre (
    .clk   (CLK),
    .rst_n (nPOR),
    .clr_i (~in_hold),
    .en_i  (in_hold),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hit) state_d = ACCESS;
      end
      ACCESS: begin
        if (!bus.BACT) begin
          cnt_d   = bus.SlowTimeout;
          state_d = (bus.SlowTimeout == '0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (hit) begin
          state_d = ACCESS;
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == TMO_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign slow_d = (state_d != IDLE);

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slow_q  <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slow_q  <= slow_d;
      gate_q  <= slow_d & bus.SlowClockGate;
    end
  end

  assign bus.Slow      = slow_q;
  assign bus.ClockGate = gate_q;

`ifdef SLOW_HITCNT_EN
  logic [HIT_W-1:0] hits_q, hits_d;
  logic             enter_acc;

  assign enter_acc = (state_d == ACCESS) & (state_q != ACCESS);

  always_comb begin
    hits_d = hits_q;
    if (bus.ClrHits) begin
      hits_d = '0;
    end else if (enter_acc && hits_q != '1) begin
      hits_d = hits_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      hits_q <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end

  assign bus.SlowHits = hits_q;
`endif

endmodule

// File: tb/tb_slow_hold_timer.sv
// Randomised and directed bench for slow_hold_timer against a
// clock-counting reference model.
module tb_slow_hold_timer;

  localparam int TDIV = 16;

  logic CLK;
  logic nPOR;
  int   vectors;
  int   miscompares;

  slow_hold_timer_if bus ();

  slow_hold_timer #(
    .TICK_DIV(TDIV)
  ) dut (
    .CLK (CLK),
    .nPOR(nPOR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: slow while in an access, then for a plain clock countdown.
  bit   m_acc;
  int   m_rem;
  int   m_hits;
  bit   m_slow;
  bit   m_gate;
  logic m_hit;

  always @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      m_acc  = 1'b0;
      m_rem  = 0;
      m_hits = 0;
      m_slow = 1'b0;
      m_gate = 1'b0;
    end else begin
      m_hit = bus.BACT & ((bus.IACKCyc & bus.SlowIACK)
            | (bus.VIACS & bus.SlowVIA) | (bus.IWMCS & bus.SlowIWM)
            | (bus.SCCCS & bus.SlowSCC) | (bus.SCSICS & bus.SlowSCSI)
            | (bus.SndCyc & bus.SlowSnd));
      if (m_acc) begin
        if (!bus.BACT) begin
          m_acc = 1'b0;
          m_rem = int'(bus.SlowTimeout) * TDIV;
        end
      end else if (m_hit) begin
        m_acc = 1'b1;
        m_rem = 0;
        if (m_hits < 255) m_hits++;
      end else if (m_rem > 0) begin
        m_rem--;
      end
`ifdef SLOW_HITCNT_EN
      if (bus.ClrHits) m_hits = 0;
`endif
      m_slow = m_acc || (m_rem > 0);
      m_gate = m_slow && bus.SlowClockGate;
    end
  end

  task automatic idle_bus();
    bus.BACT          = 1'b0;
    bus.IACKCyc       = 1'b0;
    bus.VIACS         = 1'b0;
    bus.IWMCS         = 1'b0;
    bus.SCCCS         = 1'b0;
    bus.SCSICS        = 1'b0;
    bus.SndCyc        = 1'b0;
    bus.SlowIACK      = 1'b0;
    bus.SlowVIA       = 1'b0;
    bus.SlowIWM       = 1'b0;
    bus.SlowSCC       = 1'b0;
    bus.SlowSCSI      = 1'b0;
    bus.SlowSnd       = 1'b0;
    bus.SlowClockGate = 1'b0;
    bus.SlowTimeout   = 4'd0;
`ifdef SLOW_HITCNT_EN
    bus.ClrHits       = 1'b0;
`endif
  endtask

  // Drops BACT and counts cycles Slow stays high (bounded).
  task automatic drop_and_count(output int hi);
    bus.BACT   = 1'b0;
    bus.VIACS  = 1'b0;
    bus.IWMCS  = 1'b0;
    bus.SCCCS  = 1'b0;
    hi = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (!bus.Slow) break;
      hi++;
    end
  endtask

  task automatic test_reset();
    nPOR = 1'b0;
    idle_bus();
    repeat (3) @(negedge CLK);
    vectors++;
    if (bus.Slow !== 1'b0 || bus.ClockGate !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: Slow=%b CG=%b want 0 0",
               bus.Slow, bus.ClockGate);
    end
`ifdef SLOW_HITCNT_EN
    vectors++;
    if (bus.SlowHits !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hits: got %h want 00", bus.SlowHits);
    end
`endif
    nPOR = 1'b1;
    @(negedge CLK);
    bus.SlowVIA = 1'b1;
    bus.SlowClockGate = 1'b1;
    bus.SlowTimeout = 4'd3;
    bus.BACT = 1'b1;
    bus.VIACS = 1'b1;
    repeat (2) @(negedge CLK);
    bus.BACT = 1'b0;
    bus.VIACS = 1'b0;
    repeat (5) @(negedge CLK);
    vectors++;
    if (bus.Slow !== 1'b1 || bus.ClockGate !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_hold: Slow=%b CG=%b want 1 1",
               bus.Slow, bus.ClockGate);
    end
    #2 nPOR = 1'b0;
    #1;
    vectors++;
    if (bus.Slow !== 1'b0 || bus.ClockGate !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: Slow=%b CG=%b want 0 0",
               bus.Slow, bus.ClockGate);
    end
    @(negedge CLK);
    nPOR = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      vectors++;
      if (bus.Slow !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle: cyc %0d Slow=%b want 0",
                 k, bus.Slow);
      end
    end
  endtask

  task automatic test_via_hold();
    int hi;
    idle_bus();
    bus.SlowVIA = 1'b1;
    bus.SlowTimeout = 4'd3;
    bus.SlowClockGate = 1'b1;
    @(negedge CLK);
    bus.BACT = 1'b1;
    bus.VIACS = 1'b1;
    #1;
    vectors++;
    if (bus.Slow !== 1'b0) begin
      miscompares++;
      $display("FAIL via_pre: Slow=%b want 0", bus.Slow);
    end
    @(negedge CLK);
    vectors++;
    if (bus.Slow !== 1'b1 || bus.ClockGate !== 1'b1) begin
      miscompares++;
      $display("FAIL via_rise: Slow=%b CG=%b want 1 1",
               bus.Slow, bus.ClockGate);
    end
    repeat (3) @(negedge CLK);
    drop_and_count(hi);
    vectors++;
    if (hi !== 3 * TDIV) begin
      miscompares++;
      $display("FAIL via_hold: high %0d clk want %0d", hi, 3 * TDIV);
    end
    vectors++;
    if (bus.ClockGate !== 1'b0) begin
      miscompares++;
      $display("FAIL via_gate_fall: CG=%b want 0", bus.ClockGate);
    end
  endtask

  task automatic test_scc_timeout0();
    int hi;
    idle_bus();
    bus.SlowTimeout = 4'd5;
    @(negedge CLK);
    bus.BACT = 1'b1;
    bus.SCCCS = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 4) begin
        bus.BACT = 1'b0;
        bus.SCCCS = 1'b0;
      end
      @(negedge CLK);
      vectors++;
      if (bus.Slow !== 1'b0) begin
        miscompares++;
        $display("FAIL scc_disabled: cyc %0d Slow=%b want 0",
                 k, bus.Slow);
      end
    end
    bus.SlowSCC = 1'b1;
    bus.SlowTimeout = 4'd0;
    bus.BACT = 1'b1;
    bus.SCCCS = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus.Slow !== 1'b1) begin
      miscompares++;
      $display("FAIL scc_rise: Slow=%b want 1", bus.Slow);
    end
    repeat (2) @(negedge CLK);
    drop_and_count(hi);
    vectors++;
    if (hi !== 0) begin
      miscompares++;
      $display("FAIL scc_tmo0: high %0d clk after drop want 0", hi);
    end
  endtask

  task automatic test_retrigger();
    int hi;
    idle_bus();
    bus.SlowIWM = 1'b1;
    bus.SlowTimeout = 4'd3;
    @(negedge CLK);
    bus.BACT = 1'b1;
    bus.IWMCS = 1'b1;
    repeat (2) @(negedge CLK);
    bus.BACT = 1'b0;
    bus.IWMCS = 1'b0;
    repeat (40) @(negedge CLK);
    vectors++;
    if (bus.Slow !== 1'b1) begin
      miscompares++;
      $display("FAIL retrig_mid: Slow=%b want 1", bus.Slow);
    end
    bus.SlowTimeout = 4'd9;
    bus.BACT = 1'b1;
    bus.IWMCS = 1'b1;
    @(negedge CLK);
    bus.SlowTimeout = 4'd3;
    @(negedge CLK);
    drop_and_count(hi);
    vectors++;
    if (hi !== 3 * TDIV) begin
      miscompares++;
      $display("FAIL retrig_hold: high %0d clk want %0d", hi, 3 * TDIV);
    end
  endtask

  task automatic test_clockgate_off();
    idle_bus();
    bus.SlowSnd = 1'b1;
    bus.SlowTimeout = 4'd1;
    @(negedge CLK);
    bus.BACT = 1'b1;
    bus.SndCyc = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 3) begin
        bus.BACT = 1'b0;
        bus.SndCyc = 1'b0;
      end
      @(negedge CLK);
      vectors++;
      if (bus.ClockGate !== 1'b0 || bus.Slow !== m_slow) begin
        miscompares++;
        $display("FAIL gate_off: cyc %0d CG=%b Slow=%b want 0 %b",
                 k, bus.ClockGate, bus.Slow, m_slow);
      end
    end
  endtask

  task automatic test_random();
    idle_bus();
    for (int k = 0; k < 2500; k++) begin
      @(negedge CLK);
      vectors++;
      if (bus.Slow !== m_slow || bus.ClockGate !== m_gate) begin
        miscompares++;
        $display("FAIL rand_out: cyc %0d Slow=%b CG=%b want %b %b",
                 k, bus.Slow, bus.ClockGate, m_slow, m_gate);
      end
`ifdef SLOW_HITCNT_EN
      vectors++;
      if (int'(bus.SlowHits) !== m_hits) begin
        miscompares++;
        $display("FAIL rand_hits: cyc %0d got %0d want %0d",
                 k, bus.SlowHits, m_hits);
      end
      bus.ClrHits = ($urandom_range(0, 199) == 0);
`endif
      if (bus.BACT) bus.BACT = ($urandom_range(0, 3) != 0);
      else bus.BACT = ($urandom_range(0, 19) == 0);
      bus.IACKCyc = ($urandom_range(0, 5) == 0);
      bus.VIACS   = ($urandom_range(0, 5) == 0);
      bus.IWMCS   = ($urandom_range(0, 5) == 0);
      bus.SCCCS   = ($urandom_range(0, 5) == 0);
      bus.SCSICS  = ($urandom_range(0, 5) == 0);
      bus.SndCyc  = ($urandom_range(0, 5) == 0);
      if (k % 40 == 0) begin
        bus.SlowIACK = 1'($urandom);
        bus.SlowVIA  = 1'($urandom);
        bus.SlowIWM  = 1'($urandom);
        bus.SlowSCC  = 1'($urandom);
        bus.SlowSCSI = 1'($urandom);
        bus.SlowSnd  = 1'($urandom);
        bus.SlowClockGate = 1'($urandom);
      end
      if (k % 17 == 0) bus.SlowTimeout = 4'($urandom_range(0, 3));
    end
  endtask

`ifdef SLOW_HITCNT_EN
  task automatic test_hitcnt();
    idle_bus();
    bus.SlowVIA = 1'b1;
    bus.ClrHits = 1'b1;
    @(negedge CLK);
    bus.ClrHits = 1'b0;
    for (int k = 0; k < 300; k++) begin
      bus.BACT = 1'b1;
      bus.VIACS = 1'b1;
      @(negedge CLK);
      bus.BACT = 1'b0;
      bus.VIACS = 1'b0;
      @(negedge CLK);
    end
    vectors++;
    if (bus.SlowHits !== 8'hFF || m_hits !== 255) begin
      miscompares++;
      $display("FAIL hits_sat: got %h model %0d want ff",
               bus.SlowHits, m_hits);
    end
    bus.BACT = 1'b1;
    bus.VIACS = 1'b1;
    bus.ClrHits = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus.SlowHits !== 8'h00 || bus.Slow !== 1'b1) begin
      miscompares++;
      $display("FAIL hits_clr: hits=%h Slow=%b want 00 1",
               bus.SlowHits, bus.Slow);
    end
    idle_bus();
    @(negedge CLK);
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_via_hold();
    test_scc_timeout0();
    test_retrigger();
    test_clockgate_off();
    test_random();
`ifdef SLOW_HITCNT_EN
    test_hitcnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
